// File: rtl/cmd_pkg.sv
// Shared constants and types for the custom-instruction responder.
// Opcode default, funct7 command codes, start modes and FSM states.
package cmd_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [6:0] F_LEN    = 7'h18;
  localparam logic [6:0] F_STEP   = 7'h19;
  localparam logic [6:0] F_CHAN   = 7'h1A;
  localparam logic [6:0] F_THRESH = 7'h1B;
  localparam logic [6:0] F_BASE   = 7'h20;
  localparam logic [6:0] F_START  = 7'h2B;

  localparam logic [1:0] MODE_0   = 2'b00;
  localparam logic [1:0] MODE_1   = 2'b01;
  localparam logic [1:0] MODE_2   = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [6:0]  funct7;
    logic [1:0]  rsv;
    logic [15:0] imm;
    logic [6:0]  opc;
  } instr_t;

endpackage

// File: rtl/cmd_timeout_counter.sv
// Counts EXEC cycles; expired flags the last allowed cycle.
// Held at zero whenever clear is high.
module cmd_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Expiry is seen during the final counted cycle.
  always_comb begin
    expired = enable && (count == LAST);
  end

  // Cycle counter, saturating at the last value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/custom_cmd_responder.sv
// Custom-instruction responder: config writes, job start, completion.
// One request in flight; response held until accepted.
module custom_cmd_responder
  import cmd_pkg::*;
#(
  parameter logic [6:0] OPCODE         = OPC_CUSTOM0,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_vaild,
  output logic        req_ready,
  input  logic [31:0] r_in,
  output logic        rsp_vaild,
  input  logic        rsp_ready,
  output logic        rsp_err,
  output logic [15:0] cfg_len,
  output logic [15:0] cfg_step,
  output logic [15:0] cfg_chan,
  output logic [15:0] cfg_thresh,
  output logic [15:0] cfg_base,
  output logic        job_start,
  output logic [1:0]  job_mode,
  output logic        busy,
  input  logic        job_done
);

  state_t state;
  state_t state_nx;
  instr_t instr;
  logic   err_q;
  logic   tmo_expired;
  logic   opc_ok;
  logic   is_cfg;
  logic   start_ok;
  logic   dec_err;
  logic   rsv_unused;
  logic [1:0] mode;

  assign rsv_unused = ^instr.rsv;
  assign mode = instr.imm[1:0];

  cmd_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != S_EXEC),
    .enable (state == S_EXEC),
    .expired(tmo_expired)
  );

  // Decode the latched instruction.
  always_comb begin
    opc_ok = (instr.opc == OPCODE);
    is_cfg = (instr.funct7 == F_LEN) ||
             (instr.funct7 == F_STEP) ||
             (instr.funct7 == F_CHAN) ||
             (instr.funct7 == F_THRESH) ||
             (instr.funct7 == F_BASE);
    start_ok = opc_ok && (instr.funct7 == F_START) &&
               (mode != MODE_BAD);
    dec_err = !(opc_ok && is_cfg) && !start_ok;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (req_vaild) state_nx = S_DECODE;
      S_DECODE: state_nx = start_ok ? S_EXEC : S_RESP;
      S_EXEC:   if (job_done || tmo_expired) state_nx = S_RESP;
      S_RESP:   if (rsp_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Moore outputs; req_ready is also gated by reset.
  always_comb begin
    req_ready = (state == S_IDLE) && !reset;
    busy      = (state != S_IDLE);
    rsp_vaild = (state == S_RESP);
    rsp_err   = (state == S_RESP) && err_q;
    job_start = (state == S_DECODE) && start_ok;
  end

  // Instruction latch, error flag, config and mode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr      <= '0;
      err_q      <= 1'b0;
      job_mode   <= MODE_0;
      cfg_len    <= '0;
      cfg_step   <= '0;
      cfg_chan   <= '0;
      cfg_thresh <= '0;
      cfg_base   <= '0;
    end else begin
      if (state == S_IDLE && req_vaild) begin
        instr <= instr_t'(r_in);
      end
      if (state == S_DECODE) begin
        err_q <= dec_err;
        if (start_ok) begin
          job_mode <= mode;
        end
        if (opc_ok) begin
          case (instr.funct7)
            F_LEN:    cfg_len    <= instr.imm;
            F_STEP:   cfg_step   <= instr.imm;
            F_CHAN:   cfg_chan   <= instr.imm;
            F_THRESH: cfg_thresh <= instr.imm;
            F_BASE:   cfg_base   <= instr.imm;
            default:  ;
          endcase
        end
      end
      if (state == S_EXEC && (job_done || tmo_expired)) begin
        err_q <= !job_done;
      end
    end
  end

endmodule

// File: tb/tb_custom_cmd_responder.sv
// Directed bench for custom_cmd_responder (TIMEOUT_CYCLES=16).
// Vector table for config/error commands plus job sequences.
module tb_custom_cmd_responder;
  import cmd_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_vaild;
  logic        req_ready;
  logic [31:0] r_in;
  logic        rsp_vaild;
  logic        rsp_ready;
  logic        rsp_err;
  logic [15:0] cfg_len, cfg_step, cfg_chan, cfg_thresh, cfg_base;
  logic        job_start;
  logic [1:0]  job_mode;
  logic        busy;
  logic        job_done;

  int n_chk = 0;
  int n_bad = 0;
  int starts = 0;

  custom_cmd_responder #(
    .OPCODE(7'b0001011),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_vaild(req_vaild), .req_ready(req_ready), .r_in(r_in),
    .rsp_vaild(rsp_vaild), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .cfg_len(cfg_len), .cfg_step(cfg_step), .cfg_chan(cfg_chan),
    .cfg_thresh(cfg_thresh), .cfg_base(cfg_base),
    .job_start(job_start), .job_mode(job_mode), .busy(busy),
    .job_done(job_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (job_start) starts++;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [79:0] cfg;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] mk(logic [6:0] f, logic [1:0] rv,
                                     logic [15:0] imm, logic [6:0] opc);
    return {f, rv, imm, opc};
  endfunction

  function automatic logic [79:0] cf(int a, int b, int c, int d, int e);
    return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] cfg_now();
    return {cfg_len, cfg_step, cfg_chan, cfg_thresh, cfg_base};
  endfunction

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", {79'd0, rsp_vaild}, 80'd0);
    chk("ready_back", {79'd0, req_ready}, 80'd1);
  endtask

  task automatic launch(logic [31:0] ins);
    req_vaild = 1'b1;
    r_in = ins;
    tick();
    req_vaild = 1'b0;
  endtask

  initial begin
    int s0;
    vecs[0] = '{32'b0011000_00_0000000000000110_0001011, 1'b0,
                cf(6, 0, 0, 0, 0)};
    vecs[1] = '{mk(F_STEP, 2'b00, 16'd2, OPC_CUSTOM0), 1'b0,
                cf(6, 2, 0, 0, 0)};
    vecs[2] = '{mk(F_CHAN, 2'b00, 16'd1, OPC_CUSTOM0), 1'b0,
                cf(6, 2, 1, 0, 0)};
    vecs[3] = '{mk(F_THRESH, 2'b00, 16'd12, OPC_CUSTOM0), 1'b0,
                cf(6, 2, 1, 12, 0)};
    vecs[4] = '{mk(F_BASE, 2'b00, 16'd16, OPC_CUSTOM0), 1'b0,
                cf(6, 2, 1, 12, 16)};
    vecs[5] = '{mk(F_LEN, 2'b00, 16'd99, 7'b0110011), 1'b1,
                cf(6, 2, 1, 12, 16)};
    vecs[6] = '{mk(7'h7F, 2'b00, 16'd5, OPC_CUSTOM0), 1'b1,
                cf(6, 2, 1, 12, 16)};
    vecs[7] = '{mk(F_START, 2'b00, 16'd3, OPC_CUSTOM0), 1'b1,
                cf(6, 2, 1, 12, 16)};
    vecs[8] = '{mk(F_LEN, 2'b11, 16'd7, OPC_CUSTOM0), 1'b0,
                cf(7, 2, 1, 12, 16)};

    reset = 1'b1;
    req_vaild = 1'b0;
    r_in = '0;
    rsp_ready = 1'b0;
    job_done = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", {79'd0, req_ready}, 80'd0);
    chk("rst_outs", {74'd0, rsp_vaild, rsp_err, job_start, busy, job_mode},
        80'd0);
    chk("rst_cfg", cfg_now(), 80'd0);
    reset = 1'b0;
    tick();
    chk("idle_req_ready", {79'd0, req_ready}, 80'd1);

    rsp_ready = 1'b1;
    tick();
    tick();
    rsp_ready = 1'b0;
    chk("stray_ready", {78'd0, rsp_vaild, busy}, 80'd0);

    s0 = starts;
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].instr);
      chk($sformatf("v%0d_decode", i), {78'd0, busy, rsp_vaild}, 80'd2);
      tick();
      chk($sformatf("v%0d_valid", i), {79'd0, rsp_vaild}, 80'd1);
      chk($sformatf("v%0d_err", i), {79'd0, rsp_err}, {79'd0, vecs[i].err});
      chk($sformatf("v%0d_cfg", i), cfg_now(), vecs[i].cfg);
      handshake();
    end
    chk("vec_no_start", 80'(starts - s0), 80'd0);

    s0 = starts;
    launch(32'b0101011_0000000000000000_01_0001011);
    chk("job_start_hi", {79'd0, job_start}, 80'd1);
    tick();
    chk("job_start_lo", {78'd0, job_start, busy}, 80'd1);
    chk("job_mode", {78'd0, job_mode}, 80'd1);
    req_vaild = 1'b1;
    r_in = mk(F_LEN, 2'b00, 16'h55, OPC_CUSTOM0);
    chk("busy_not_ready", {79'd0, req_ready}, 80'd0);
    tick();
    req_vaild = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("exec_wait", {79'd0, rsp_vaild}, 80'd0);
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    chk("job_rsp", {78'd0, rsp_vaild, rsp_err}, 80'd2);
    handshake();
    chk("job_pulses", 80'(starts - s0), 80'd1);
    chk("busy_req_ignored", cfg_now(), cf(7, 2, 1, 12, 16));
    chk("mode_hold", {78'd0, job_mode}, 80'd1);

    launch(mk(F_START, 2'b00, 16'd2, OPC_CUSTOM0));
    tick();
    for (int i = 0; i < 15; i++) tick();
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    chk("tie_success", {78'd0, rsp_vaild, rsp_err}, 80'd2);
    chk("mode2", {78'd0, job_mode}, 80'd2);
    handshake();

    launch(mk(F_START, 2'b00, 16'd0, OPC_CUSTOM0));
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_early", {79'd0, rsp_vaild}, 80'd0);
    tick();
    chk("tmo_rsp", {78'd0, rsp_vaild, rsp_err}, 80'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("tmo_hold%0d", i), {78'd0, rsp_vaild, rsp_err}, 80'd3);
    end
    handshake();

    launch(mk(F_START, 2'b00, 16'd1, OPC_CUSTOM0));
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", {79'd0, req_ready}, 80'd0);
    reset = 1'b0;
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    chk("abort_state", {77'd0, rsp_vaild, busy, req_ready}, 80'd1);
    chk("abort_cfg", cfg_now(), 80'd0);
    chk("abort_mode", {78'd0, job_mode}, 80'd0);
    tick();
    tick();
    chk("abort_no_rsp", {78'd0, rsp_vaild, busy}, 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
